// File: rtl/man_pkg.sv
// Shared types and chip-mapping helper for the Manchester transmit path.
package man_pkg;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} man_state_e;

   localparam logic [1:0] CHIP_ONE  = 2'b01;
   localparam logic [1:0] CHIP_ZERO = 2'b10;

   // Widest word man_expand handles; callers keep only the low 2*DATA_W bits.
   localparam int MAN_MAX_W      = 64;
   localparam int MAN_IDX_W      = $clog2(MAN_MAX_W);
   localparam int MAN_CHIP_IDX_W = MAN_IDX_W + 1;

   // Chip k in transmission order lands at bit k; each pair is sent left to right.
   function automatic logic [2*MAN_MAX_W-1:0] man_expand(
      input logic [MAN_MAX_W-1:0] data,
      input int                   data_w,
      input logic                 polarity,
      input logic                 msb_first
   );
      logic [2*MAN_MAX_W-1:0] chips;
      logic [1:0]             pair;
      logic                   b;
      chips = '0;
      for (int i = 0; i < MAN_MAX_W; i++) begin
         if (i < data_w) begin
            b    = msb_first ? data[MAN_IDX_W'(data_w - 1 - i)] : data[MAN_IDX_W'(i)];
            pair = (b ^ polarity) ? CHIP_ONE : CHIP_ZERO;
            chips[MAN_CHIP_IDX_W'(2*i)]     = pair[1];
            chips[MAN_CHIP_IDX_W'(2*i + 1)] = pair[0];
         end
      end
      return chips;
   endfunction

endpackage

// File: rtl/man_encoder_tx_fifo.sv
// Synchronous FIFO feeding the Manchester encoder; head word readable without a pop.
module man_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk_in) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/man_encoder_tx.sv
// Manchester line encoder: FIFO-buffered words serialised as gapless chip streams.
//
// state | meaning
// IDLE  | line parked at IDLE_LVL, waiting for a queued word
// SHIFT | chips of a word on code; the next queued word is chained at the last chip
module man_encoder_tx
   import man_pkg::*;
#(
   parameter int   DATA_W     = 8,
   parameter int   HALF_DIV   = 150,
   parameter int   FIFO_DEPTH = 4,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LVL   = 1'b0
) (
   input  logic                          clk_in,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          in_ready,
   input  logic                          polarity,
   output logic                          code,
   output logic                          line_active,
   output logic                          frame_done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CHIPS = 2 * DATA_W;
   localparam int DIV_W = $clog2(HALF_DIV) + 1;
   localparam int CNT_W = $clog2(CHIPS) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHIPS - 1);

   man_state_e state;
   man_state_e state_nxt;

   logic [DIV_W-1:0]       div_cnt;
   logic [CNT_W-1:0]       chip_cnt;
   logic [CHIPS-1:0]       sreg;
   logic [CHIPS-1:0]       chips_new;
   logic [2*MAN_MAX_W-1:0] exp_full_unused;
   logic [MAN_MAX_W-1:0]   data_ext;
   logic [DATA_W-1:0]      fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   load;
   logic                   advance;
   logic                   word_end;
   logic                   ready_en;

   assign push = in_valid && in_ready;

   man_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in (clk_in),
      .rst    (rst),
      .push   (push),
      .pop    (load),
      .din    (in_data),
      .dout   (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level)
   );

   always_comb begin
      data_ext              = '0;
      data_ext[DATA_W-1:0]  = fifo_head;
   end

   // Polarity is only looked at here, so a mid-word change cannot reach the line.
   assign exp_full_unused = man_expand(data_ext, DATA_W, polarity, MSB_FIRST);
   assign chips_new       = exp_full_unused[CHIPS-1:0];

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      advance   = 1'b0;
      word_end  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (div_cnt == '0) begin
               if (chip_cnt != '0) begin
                  advance = 1'b1;
               end else begin
                  word_end = 1'b1;
                  if (!fifo_empty) load = 1'b1;
                  else             state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      line_active = (state == SHIFT);
      busy        = !fifo_empty || (state == SHIFT);
      in_ready    = ready_en && !fifo_full;
   end

   // Both counters run down to zero: div_cnt paces a chip, chip_cnt counts chips left.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         div_cnt    <= '0;
         chip_cnt   <= '0;
         sreg       <= '0;
         code       <= IDLE_LVL;
         frame_done <= 1'b0;
         ready_en   <= 1'b0;
      end else begin
         ready_en   <= 1'b1;
         frame_done <= word_end;
         if (load) begin
            sreg     <= chips_new;
            code     <= chips_new[0];
            div_cnt  <= DIV_LAST;
            chip_cnt <= CNT_LAST;
         end else if (advance) begin
            sreg     <= {1'b0, sreg[CHIPS-1:1]};
            code     <= sreg[1];
            div_cnt  <= DIV_LAST;
            chip_cnt <= chip_cnt - CNT_W'(1);
         end else if (word_end) begin
            code     <= IDLE_LVL;
         end else if (state == SHIFT) begin
            div_cnt  <= div_cnt - DIV_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_man_encoder_tx.sv
// Bench for man_encoder_tx: scoreboarded chip stream on a HALF_DIV=4 build, hand sequence on an LSB-first HALF_DIV=1 build.
module tb_man_encoder_tx;

   localparam int DW    = 8;
   localparam int HD    = 4;
   localparam int DEPTH = 4;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          polarity;
   logic          in_ready;
   logic          code;
   logic          line_active;
   logic          frame_done;
   logic          busy;
   logic [2:0]    fifo_level;

   logic          b_in_valid;
   logic [DW-1:0] b_in_data;
   logic          b_polarity;
   logic          b_in_ready;
   logic          b_code;
   logic          b_line_active;
   logic          b_frame_done;
   logic          b_busy;
   logic [2:0]    b_fifo_level;

   man_encoder_tx #(
      .DATA_W(DW), .HALF_DIV(HD), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)
   ) dut (
      .clk_in(clk_in), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .polarity(polarity), .code(code),
      .line_active(line_active), .frame_done(frame_done), .busy(busy),
      .fifo_level(fifo_level)
   );

   man_encoder_tx #(
      .DATA_W(DW), .HALF_DIV(1), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)
   ) dut_lsb (
      .clk_in(clk_in), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
      .in_ready(b_in_ready), .polarity(b_polarity), .code(b_code),
      .line_active(b_line_active), .frame_done(b_frame_done), .busy(b_busy),
      .fifo_level(b_fifo_level)
   );

   typedef struct { logic code; logic last; } sb_t;
   typedef struct { logic [7:0] data; logic pol; logic [15:0] chips; } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[4];
   logic [7:0] bp_words[6];

   int total  = 0;
   int bad    = 0;
   int stalls = 0;
   int fd_cnt = 0;
   logic mon_en      = 1'b0;
   logic exp_fd      = 1'b0;
   logic prev_active = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Independent chip model: first chip in bit 15, one pair per data bit.
   function automatic logic [15:0] ref_chips(input logic [7:0] d, input logic pol, input bit msb);
      logic [15:0] r;
      logic [7:0]  s;
      logic        e;
      r = '0;
      s = d;
      for (int i = 0; i < 8; i++) begin
         e = (msb ? s[7] : s[0]) ^ pol;
         r = {r[13:0], ~e, e};
         s = msb ? (s << 1) : (s >> 1);
      end
      return r;
   endfunction

   task automatic expect_word(input logic [15:0] chips);
      logic [15:0] c;
      c = chips;
      for (int k = 0; k < 16; k++) begin
         for (int r = 0; r < HD; r++)
            sb_q.push_back('{code: c[15], last: (k == 15 && r == HD - 1)});
         c = c << 1;
      end
   endtask

   // Called at posedge+1; leaves in_valid high so callers can stream words.
   task automatic send(input logic [7:0] d, input logic [15:0] chips);
      bit ok;
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         ok = in_ready;
         if (!ok) begin
            stalls++;
            check("level_at_stall", fifo_level, DEPTH);
         end
         @(posedge clk_in); #1;
         n++;
      end while (!ok && n < 1000);
      check("accept_timeout", ok, 1);
      expect_word(chips);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 3000) begin
         @(posedge clk_in); #1;
         n++;
      end
      check("idle_timeout", n < 3000, 1);
      repeat (3) begin @(posedge clk_in); #1; end
      check("sb_drained", sb_q.size(), 0);
   endtask

   always @(negedge clk_in) begin
      if (mon_en) begin
         sb_t e;
         check("frame_done", frame_done, exp_fd);
         if (frame_done) fd_cnt++;
         exp_fd = 1'b0;
         if (line_active) begin
            check("sb_has_entry", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("code", code, e.code);
               exp_fd = e.last;
            end
         end else begin
            check("idle_code", code, 1'b0);
            if (prev_active && sb_q.size() != 0) check("no_gap", line_active, 1);
         end
         prev_active = line_active;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      int f0;
      logic [33:0] cs, las, fds;

      vecs[0] = '{data: 8'hA5, pol: 1'b0, chips: 16'h6699};
      vecs[1] = '{data: 8'h01, pol: 1'b1, chips: 16'h5556};
      vecs[2] = '{data: 8'h3C, pol: 1'b0, chips: 16'hA55A};
      vecs[3] = '{data: 8'h81, pol: 1'b1, chips: 16'h9556};
      bp_words = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h3C, 8'h81};

      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; polarity = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_polarity = 1'b0;

      #12;
      check("rst_code", code, 0);
      check("rst_line_active", line_active, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_busy", busy, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_in_ready", in_ready, 0);
      @(negedge clk_in) rst = 1'b0;
      @(posedge clk_in); #1;
      check("ready_after_release", in_ready, 1);
      mon_en = 1'b1;

      foreach (vecs[i]) begin
         polarity = vecs[i].pol;
         send(vecs[i].data, vecs[i].chips);
         in_valid = 1'b0;
         wait_idle();
      end

      polarity = 1'b0;
      f0 = fd_cnt;
      send(8'h00, 16'hAAAA);
      send(8'hFF, 16'h5555);
      in_valid = 1'b0;
      wait_idle();
      check("b2b_frames", fd_cnt - f0, 2);

      stalls = 0;
      f0 = fd_cnt;
      foreach (bp_words[i]) send(bp_words[i], ref_chips(bp_words[i], 1'b0, 1'b1));
      in_valid = 1'b0;
      wait_idle();
      check("bp_stalled", stalls > 0, 1);
      check("bp_frames", fd_cnt - f0, 6);

      polarity = 1'b1;
      send(8'h01, 16'h5556);
      send(8'h3C, 16'hA55A);
      in_valid = 1'b0;
      repeat (9) @(posedge clk_in);
      #1 polarity = 1'b0;
      wait_idle();

      send(8'hA5, 16'h6699);
      send(8'h00, 16'hAAAA);
      send(8'hFF, 16'h5555);
      in_valid = 1'b0;
      repeat (8) @(posedge clk_in);
      #1;
      check("level_before_rst", fifo_level, 2);
      check("active_before_rst", line_active, 1);
      f0 = fd_cnt;
      rst = 1'b1;
      sb_q.delete();
      exp_fd = 1'b0;
      #1;
      check("midrst_code", code, 0);
      check("midrst_line_active", line_active, 0);
      check("midrst_fifo_level", fifo_level, 0);
      check("midrst_busy", busy, 0);
      check("midrst_frame_done", frame_done, 0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in) rst = 1'b0;
      @(posedge clk_in); #1;
      check("midrst_no_frame", fd_cnt - f0, 0);
      send(8'h3C, 16'hA55A);
      in_valid = 1'b0;
      wait_idle();
      check("post_rst_frames", fd_cnt - f0, 1);

      check("lsb_ready", b_in_ready, 1);
      b_in_valid = 1'b1;
      b_in_data  = 8'h01;
      b_polarity = 1'b0;
      @(posedge clk_in); #1;
      b_in_data = 8'h80;
      @(posedge clk_in); #1;
      b_in_valid = 1'b0;
      cs = '0; las = '0; fds = '0;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk_in);
         cs  = {cs[32:0], b_code};
         las = {las[32:0], b_line_active};
         fds = {fds[32:0], b_frame_done};
      end
      check("lsb_code_stream", cs, {16'h6AAA, 16'hAAA9, 2'b00});
      check("lsb_line_active", las, {32'hFFFF_FFFF, 2'b00});
      check("lsb_frame_done", fds, {16'b0, 1'b1, 15'b0, 1'b1, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/man_encoder_tx.md
Name: man_encoder_tx

Overview:
- Parametrised Manchester line encoder and successor to the byte-wide encoder fed by the UART receive path.
- Accepts words over a valid/ready handshake into a small FIFO, and derives chip timing from the system clock through an internal divider; no separate bit-rate clock.
- Serialises each word as Manchester chips, gapless back-to-back, with selectable polarity and bit order.
- Sits between the UART RX / framing logic and the line driver.

Parameters:
- DATA_W, 8, bits per word (≥1).
- HALF_DIV, 150, clk_in cycles per chip, i.e. per half-bit (≥1).
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2).
- MSB_FIRST, 1, 1: word MSB transmitted first; 0: LSB first.
- IDLE_LVL, 0, level driven on code when not transmitting.

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  word offered.
- in_data  in  DATA_W  word to encode.
- in_ready  out  1  FIFO can accept; transfer occurs on an edge where in_valid && in_ready.
- polarity  in  1  0: bit 1 -> chips 0,1 and bit 0 -> 1,0. 1: inverted mapping. Sampled at word load.
- code  out  1  Manchester line output (registered).
- line_active  out  1  high while chips of a word are on code.
- frame_done  out  1  one-cycle pulse on the edge that ends the last chip of a word.
- busy  out  1  FIFO non-empty or line_active.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, immediate, also when asserted mid-word): code=IDLE_LVL, line_active=0, frame_done=0, busy=0, fifo_level=0, FIFO flushed.
  - in_ready=1 from the first edge after release.
  - A word in flight is abandoned with no frame_done.
- FIFO behaviour:
  - in_ready = (fifo_level != FIFO_DEPTH).
  - Push and pop on the same edge leave the level unchanged.
  - No push occurs while full; no data is ever dropped.
- FSM states:
  - IDLE: line_active=0, code=IDLE_LVL.
  - SHIFT: transmitting.
- IDLE -> SHIFT: on an edge with FIFO non-empty:
  - Pop the head word and build a 2*DATA_W chip vector using the current polarity and MSB_FIRST.
  - Register code = first chip, line_active=1, div_cnt=0, chip_cnt=0.
- SHIFT, per edge:
  - div_cnt increments.
  - At div_cnt==HALF_DIV-1: div_cnt=0.
    - If chip_cnt < 2*DATA_W-1: chip_cnt++, code = next chip.
    - Otherwise pulse frame_done, then:
      - if FIFO non-empty: pop and load the next word in the same edge, so code = its first chip with zero gap and line_active stays 1;
      - else: -> IDLE, code=IDLE_LVL, line_active=0.
- Latency:
  - A word pushed into an empty FIFO while IDLE is popped on the next edge.
  - Its first chip is on code from that edge onward.
  - Each word occupies exactly 2*DATA_W*HALF_DIV cycles of code.
- polarity changes take effect only at the next word load; a mid-word change is ignored.
- HALF_DIV=1: code changes every cycle and the divider is degenerate; this must still be correct.
- Counter widths: div_cnt $clog2(HALF_DIV)+1, chip_cnt $clog2(2*DATA_W)+1. No wrap-around beyond the terminal compare.

Decomposition:
- Package man_pkg holds:
  - FSM state enum {IDLE, SHIFT};
  - chip constants CHIP_ONE=2'b01 and CHIP_ZERO=2'b10;
  - function man_expand(data, polarity, msb_first) returning the 2*DATA_W chip vector.
- Sub-module man_fifo: synchronous FIFO, parametrised width and depth, with push/pop/full/empty/level. It uses the same clk_in/rst convention.
- Divider, shift register and FSM stay in man_encoder_tx.

Test Plan:
- Single word, DATA_W=8, HALF_DIV=4, polarity=0, MSB first: push 0xA5 -> code = 01 10 01 10 10 01 10 01, each chip held 4 cycles. line_active high for 64 cycles, one frame_done on the final edge, then code=0.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles -> 8×(1,0) then 8×(0,1) chips, line_active continuously high for 128 cycles, exactly two frame_done pulses 64 cycles apart.
- Backpressure: hold in_valid with 6 distinct words while HALF_DIV=4 -> in_ready drops when fifo_level=4. All 6 words are emitted in order with no loss and no inter-word gap.
- Polarity: polarity=1, push 0x01 -> chips 01×7 then 10. Toggling polarity at cycle 10 of that word leaves its chips unchanged; the next word uses the new mapping.
- MSB_FIRST=0 build: push 0x01 with polarity=0 -> first chip pair 01, remaining seven pairs 10.
- Reset mid-word: assert rst 10 cycles into a word with 2 words queued -> code=0, line_active=0, fifo_level=0 immediately, no frame_done. After release, a new push transmits normally.
